// File: rtl/fpnew_issue_ctrl.sv
// Tags FP requests, issues them to the FPU, and reorders results back to the client in issue order.
// Latency: request->FPU is combinational; a result captured at edge N can be presented at cycle N+1.
// Backpressure: issue stalls when all DEPTH tags are in flight; results wait in the ROB while resp is stalled.
module fpnew_issue_ctrl #(
  parameter int FLEN      = 64,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3*FLEN-1:0]    req_operands_i,
  input  logic [16:0]          req_ctrl_i,
  input  logic                 flush_i,
  output logic                 fpu_in_valid_o,
  input  logic                 fpu_in_ready_i,
  output logic [3*FLEN-1:0]    fpu_operands_o,
  output logic [16:0]          fpu_ctrl_o,
  output logic [TAG_WIDTH-1:0] fpu_tag_o,
  output logic                 fpu_flush_o,
  input  logic                 fpu_out_valid_i,
  output logic                 fpu_out_ready_o,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [4:0]           fpu_status_i,
  input  logic [TAG_WIDTH-1:0] fpu_tag_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [FLEN-1:0]      resp_result_o,
  output logic [4:0]           resp_status_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int DEPTH = 2 ** TAG_WIDTH;

  logic [TAG_WIDTH-1:0] alloc_ptr;
  logic [TAG_WIDTH-1:0] retire_ptr;
  logic [TAG_WIDTH:0]   count;
  logic [DEPTH-1:0]     pending;
  logic [DEPTH-1:0]     done;
  logic [FLEN-1:0]      result_q [DEPTH];
  logic [4:0]           status_q [DEPTH];

  logic full;
  logic issue_fire;
  logic res_ok;
  logic res_bad;
  logic resp_fire;

  // Handshake decode: full uses the registered count, so a retire never frees a slot for the same cycle.
  always_comb begin
    full           = (count == (TAG_WIDTH+1)'(DEPTH));
    fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
    req_ready_o    = fpu_in_ready_i & ~full & ~flush_i;
    issue_fire     = req_valid_i & req_ready_o;
    fpu_operands_o = req_operands_i;
    fpu_ctrl_o     = req_ctrl_i;
    fpu_tag_o      = alloc_ptr;
    fpu_flush_o    = flush_i;
    fpu_out_ready_o = 1'b1;
    // A result is only legal for an entry that is in flight and has not yet completed.
    res_ok         = fpu_out_valid_i & ~flush_i & pending[fpu_tag_i] & ~done[fpu_tag_i];
    res_bad        = fpu_out_valid_i & ~flush_i & ~(pending[fpu_tag_i] & ~done[fpu_tag_i]);
    resp_valid_o   = done[retire_ptr];
    resp_result_o  = result_q[retire_ptr];
    resp_status_o  = status_q[retire_ptr];
    resp_fire      = resp_valid_o & resp_ready_i & ~flush_i;
    busy_o         = (count != '0);
  end

  // Pointer, occupancy and per-entry lifecycle (FREE -> PENDING -> DONE -> FREE).
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
      pending    <= '0;
      done       <= '0;
    end else begin
      if (issue_fire) alloc_ptr <= alloc_ptr + 1'b1;
      if (resp_fire)  retire_ptr <= retire_ptr + 1'b1;
      case ({issue_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (resp_fire && retire_ptr == TAG_WIDTH'(i)) begin
          pending[i] <= 1'b0;
          done[i]    <= 1'b0;
        end
        if (issue_fire && alloc_ptr == TAG_WIDTH'(i)) pending[i] <= 1'b1;
        if (res_ok && fpu_tag_i == TAG_WIDTH'(i))     done[i]    <= 1'b1;
      end
    end
  end

  // Result storage, written only by an accepted result for its own tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        status_q[i] <= '0;
      end
    end else if (res_ok) begin
      result_q[fpu_tag_i] <= fpu_result_i;
      status_q[fpu_tag_i] <= fpu_status_i;
    end
  end

  // Sticky protocol error; survives flush, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)        err_o <= 1'b0;
    else if (res_bad) err_o <= 1'b1;
  end

endmodule
